mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 218 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: decodes size/sign, places store data on byte lanes,
// drives a single outstanding MMU request and returns extended load data or a fault.
module mem_access_unit #(
  parameter int XLEN        = 64,
  parameter int ADDR_W      = 64,
  parameter int TIMEOUT     = 255,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic              flush,
  output logic              mmu_valid,
  output logic              mmu_write,
  output logic [ADDR_W-1:0] mmu_addr,
  output logic [XLEN-1:0]   mmu_wdata,
  output logic [XLEN/8-1:0] mmu_wstrb,
  input  logic              mmu_ready,
  input  logic [XLEN-1:0]   mmu_rdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              fault,
  output logic [1:0]        fault_cause
);

  localparam int BYTES  = XLEN / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int IDX_W  = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                discard_q, discard_d;
  logic                mmu_valid_q, mmu_valid_d;
  logic                mmu_write_q, mmu_write_d;
  logic [ADDR_W-1:0]   mmu_addr_q, mmu_addr_d;
  logic [XLEN-1:0]     mmu_wdata_q, mmu_wdata_d;
  logic [BYTES-1:0]    mmu_wstrb_q, mmu_wstrb_d;
  logic [2:0]          f3_q, f3_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic [1:0]          cause_q, cause_d;

  // Request decode
  logic [LANE_W-1:0]   req_lane;
  logic [3:0]          req_nbytes;
  int                  req_nbits;
  logic                req_illegal;
  logic                req_misal;
  logic [BYTES-1:0]    req_strb;
  logic [XLEN-1:0]     req_wmask;
  logic [XLEN-1:0]     req_placed;

  always_comb begin
    req_lane    = req_addr[LANE_W-1:0];
    req_nbytes  = 4'd1 << req_funct3[1:0];
    req_nbits   = 8 << req_funct3[1:0];
    req_illegal = (req_funct3 == 3'b111) ||
                  ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));
    req_misal   = (ALIGN_CHECK != 0) &&
                  ((req_lane & LANE_W'(req_nbytes - 4'd1)) != '0);
    req_strb    = BYTES'(((16'd1 << req_nbytes) - 16'd1) << req_lane);
    req_placed  = (req_wdata & req_wmask) << {req_lane, 3'b000};
  end

  // Load extraction works from the registered request so it lines up with mmu_rdata
  logic [LANE_W-1:0]   acc_lane;
  logic [XLEN-1:0]     rd_shift;
  int                  acc_nbits;
  logic [IDX_W-1:0]    sign_idx;
  logic                sign_bit;
  logic [XLEN-1:0]     load_ext;

  always_comb begin
    acc_lane  = mmu_addr_q[LANE_W-1:0];
    rd_shift  = mmu_rdata >> {acc_lane, 3'b000};
    acc_nbits = 8 << f3_q[1:0];
    case (f3_q[1:0])
      2'd0:    sign_idx = IDX_W'(7);
      2'd1:    sign_idx = IDX_W'(15);
      2'd2:    sign_idx = IDX_W'(31);
      default: sign_idx = IDX_W'(XLEN - 1);
    endcase
    sign_bit = !f3_q[2] && rd_shift[sign_idx];
  end

  for (genvar gi = 0; gi < XLEN; gi++) begin : g_bits
    assign req_wmask[gi] = (gi < req_nbits);
    assign load_ext[gi]  = (gi < acc_nbits) ? rd_shift[gi] : sign_bit;
  end

  logic timeout_hit;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    discard_d   = discard_q;
    mmu_valid_d = mmu_valid_q;
    mmu_write_d = mmu_write_q;
    mmu_addr_d  = mmu_addr_q;
    mmu_wdata_d = mmu_wdata_q;
    mmu_wstrb_d = mmu_wstrb_q;
    f3_d        = f3_q;
    rdata_d     = rdata_q;
    cause_d     = cause_q;
    timeout_hit = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          if (req_illegal) begin
            state_d = DONE;
            cause_d = 2'b11;
            rdata_d = '0;
          end else if (req_misal) begin
            state_d = DONE;
            cause_d = 2'b01;
            rdata_d = '0;
          end else begin
            state_d     = ACCESS;
            mmu_valid_d = 1'b1;
            mmu_write_d = req_write;
            mmu_addr_d  = req_addr;
            mmu_wdata_d = req_write ? req_placed : '0;
            mmu_wstrb_d = req_write ? req_strb : '0;
            f3_d        = req_funct3;
            cnt_d       = '0;
            discard_d   = 1'b0;
            cause_d     = 2'b00;
            rdata_d     = '0;
          end
        end
      end

      ACCESS: begin
        timeout_hit = ({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT);
        if (mmu_ready || timeout_hit) begin
          mmu_valid_d = 1'b0;
          mmu_write_d = 1'b0;
          mmu_addr_d  = '0;
          mmu_wdata_d = '0;
          mmu_wstrb_d = '0;
          cnt_d       = '0;
          discard_d   = 1'b0;
          // A flush seen at any point of the access, including this cycle, drops the result
          if (discard_q || flush) begin
            state_d = IDLE;
            cause_d = 2'b00;
            rdata_d = '0;
          end else if (mmu_ready) begin
            state_d = DONE;
            cause_d = 2'b00;
            rdata_d = mmu_write_q ? '0 : load_ext;
          end else begin
            state_d = DONE;
            cause_d = 2'b10;
            rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (flush) discard_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        cause_d = 2'b00;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      discard_q   <= 1'b0;
      mmu_valid_q <= 1'b0;
      mmu_write_q <= 1'b0;
      mmu_addr_q  <= '0;
      mmu_wdata_q <= '0;
      mmu_wstrb_q <= '0;
      f3_q        <= '0;
      rdata_q     <= '0;
      cause_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      discard_q   <= discard_d;
      mmu_valid_q <= mmu_valid_d;
      mmu_write_q <= mmu_write_d;
      mmu_addr_q  <= mmu_addr_d;
      mmu_wdata_q <= mmu_wdata_d;
      mmu_wstrb_q <= mmu_wstrb_d;
      f3_q        <= f3_d;
      rdata_q     <= rdata_d;
      cause_q     <= cause_d;
    end
  end

  assign mmu_valid   = mmu_valid_q;
  assign mmu_write   = mmu_write_q;
  assign mmu_addr    = mmu_addr_q;
  assign mmu_wdata   = mmu_wdata_q;
  assign mmu_wstrb   = mmu_wstrb_q;
  assign rsp_valid   = (state_q == DONE) && !flush;
  assign rsp_rdata   = rdata_q;
  assign fault       = rsp_valid && (cause_q != 2'b00);
  assign fault_cause = rsp_valid ? cause_q : 2'b00;
  assign stall       = rst && (((state_q == IDLE) && req_valid) || (state_q == ACCESS));

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: each transaction's expected cycle-by-cycle
// behaviour is derived from size/alignment/latency rules with plain arithmetic.
module tb_mem_access_unit;
  localparam int XLEN = 64;
  localparam int ADDR_W = 64;
  localparam int TO = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_write, flush, mmu_ready;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata, mmu_rdata;
  logic              mmu_valid, mmu_write, stall, rsp_valid, fault;
  logic [ADDR_W-1:0] mmu_addr;
  logic [XLEN-1:0]   mmu_wdata, rsp_rdata;
  logic [7:0]        mmu_wstrb;
  logic [1:0]        fault_cause;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TO), .ALIGN_CHECK(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .mmu_valid(mmu_valid), .mmu_write(mmu_write), .mmu_addr(mmu_addr),
    .mmu_wdata(mmu_wdata), .mmu_wstrb(mmu_wstrb), .mmu_ready(mmu_ready),
    .mmu_rdata(mmu_rdata), .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .fault(fault), .fault_cause(fault_cause)
  );

  int checks = 0;
  int errors = 0;
  int txn = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] size_mask(input int nb);
    if (nb >= 8) return '1;
    return (64'd1 << (8 * nb)) - 64'd1;
  endfunction

  // ready_at: cycle with mmu_ready (beyond TO = never in time); flush_at: -1 none, 0 with request
  task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rdata,
                         input int ready_at, input int flush_at);
    int nb, lane, e_end, resp_c;
    logic illegal, misal, acc, timed_out, discard, rsp_exp;
    logic exp_mv, exp_rv;
    logic [63:0] e_wdata, e_rdata, v;
    logic [7:0] e_strb;
    logic [1:0] e_cause;
    string pfx;

    nb = 1 << f3[1:0];
    lane = int'(addr[2:0]);
    illegal = (f3 == 3'b111);
    misal = (lane % nb) != 0;
    acc = (flush_at != 0) && !illegal && !misal;
    if (acc) begin
      timed_out = !(ready_at >= 1 && ready_at <= TO);
      e_end = timed_out ? TO : ready_at;
      resp_c = e_end + 1;
      discard = (flush_at >= 1) && (flush_at <= e_end);
      e_cause = timed_out ? 2'b10 : 2'b00;
    end else begin
      timed_out = 1'b0;
      e_end = 0;
      discard = 1'b0;
      resp_c = (flush_at == 0) ? -1 : 1;
      e_cause = illegal ? 2'b11 : 2'b01;
    end
    rsp_exp = (resp_c > 0) && !discard && (flush_at != resp_c);
    e_strb = wr ? 8'(((1 << nb) - 1) << lane) : 8'h00;
    e_wdata = wr ? ((wdata & size_mask(nb)) << (8 * lane)) : 64'd0;
    v = (rdata >> (8 * lane)) & size_mask(nb);
    if (!f3[2] && nb < 8 && v[8 * nb - 1]) v = v | ~size_mask(nb);
    e_rdata = (wr || timed_out || !acc) ? 64'd0 : v;

    txn++;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr;
    req_wdata = wdata; flush = (flush_at == 0); mmu_ready = 1'b0; mmu_rdata = rdata;
    @(negedge clk);
    pfx = $sformatf("t%0d_c0", txn);
    check({pfx, "_stall"}, 64'(stall), 64'd1);
    check({pfx, "_mv"}, 64'(mmu_valid), 64'd0);

    for (int c = 1; c <= e_end + 2; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      flush = (c == flush_at);
      mmu_ready = (c == ready_at);
      @(negedge clk);
      pfx = $sformatf("t%0d_c%0d", txn, c);
      exp_mv = acc && (c <= e_end);
      exp_rv = rsp_exp && (c == resp_c);
      check({pfx, "_mv"}, 64'(mmu_valid), 64'(exp_mv));
      check({pfx, "_rv"}, 64'(rsp_valid), 64'(exp_rv));
      check({pfx, "_stall"}, 64'(stall), 64'(exp_mv));
      if (exp_mv) begin
        check({pfx, "_maddr"}, mmu_addr, addr);
        check({pfx, "_mwr"}, 64'(mmu_write), 64'(wr));
        check({pfx, "_mwdata"}, mmu_wdata, e_wdata);
        check({pfx, "_mwstrb"}, 64'(mmu_wstrb), 64'(e_strb));
      end
      if (exp_rv) begin
        check({pfx, "_fault"}, {61'd0, fault, fault_cause}, {61'd0, e_cause != 2'b00, e_cause});
        check({pfx, "_rdata"}, rsp_rdata, e_rdata);
      end else begin
        check({pfx, "_nofault"}, {61'd0, fault, fault_cause}, 64'd0);
      end
    end
    $display("txn %0d wr=%0d f3=%0d addr=%h ready_at=%0d flush_at=%0d rsp=%0d cause=%0d",
             txn, wr, f3, addr, ready_at, flush_at, rsp_exp, e_cause);
  endtask

  initial begin
    logic [2:0] f3;
    logic [63:0] addr;
    logic wr;
    int nb, ready_at, flush_at;

    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0;
    req_wdata = '0; flush = 1'b0; mmu_ready = 1'b0; mmu_rdata = '0;
    #3;
    check("rst_mv", 64'(mmu_valid), 64'd0);
    check("rst_outs", {59'd0, stall, rsp_valid, fault, fault_cause}, 64'd0);
    check("rst_wstrb", 64'(mmu_wstrb), 64'd0);
    check("rst_rdata", rsp_rdata, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // lb with sign extension, minimum latency
    run_txn(1'b0, 3'b000, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 1, -1);
    // sh to lane 6
    run_txn(1'b1, 3'b001, 64'h2006, 64'hBEEF, 64'd0, 2, -1);
    // misaligned lw
    run_txn(1'b0, 3'b010, 64'h1002, 64'd0, 64'd0, 1, -1);
    // illegal size
    run_txn(1'b0, 3'b111, 64'h1000, 64'd0, 64'd0, 1, -1);
    // timeout, then ready coinciding with the timeout cycle
    run_txn(1'b0, 3'b011, 64'h3000, 64'd0, 64'h1122_3344_5566_7788, 100, -1);
    run_txn(1'b0, 3'b011, 64'h3008, 64'd0, 64'h8122_3344_5566_7788, TO, -1);
    // flush during access, flush in DONE, flush with request in IDLE
    run_txn(1'b0, 3'b010, 64'h4004, 64'd0, 64'hFFFF_FFFF_0000_0000, 5, 2);
    run_txn(1'b0, 3'b110, 64'h4004, 64'd0, 64'h8000_0000_0000_0000, 1, 2);
    run_txn(1'b1, 3'b000, 64'h5001, 64'hA5, 64'd0, 1, 0);
    run_txn(1'b0, 3'b101, 64'h5002, 64'd0, 64'h0000_0000_F00D_0000, 3, -1);

    for (int k = 0; k < 80; k++) begin
      f3 = 3'($urandom_range(0, 7));
      wr = 1'($urandom_range(0, 1));
      nb = 1 << f3[1:0];
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr = addr & ~64'(nb - 1);
      ready_at = int'($urandom_range(1, TO + 2));
      flush_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, TO + 1)) : -1;
      run_txn(wr, f3, addr, {$urandom, $urandom}, {$urandom, $urandom}, ready_at, flush_at);
    end

    // Reset asserted in the middle of an access
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b011; req_addr = 64'h6000; flush = 1'b0;
    mmu_ready = 1'b0;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    check("rstmid_mv_before", 64'(mmu_valid), 64'd1);
    rst = 1'b0;
    #1;
    check("rstmid_mv", 64'(mmu_valid), 64'd0);
    check("rstmid_outs", {61'd0, stall, rsp_valid, fault}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("rstpost_c%0d", c), {62'd0, mmu_valid, rsp_valid}, 64'd0);
    end

    // First request presented while in reset is taken on the first edge after release
    rst = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b100; req_addr = 64'h7005;
    mmu_rdata = 64'h0000_9A00_0000_0000;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0; mmu_ready = 1'b1;
    @(negedge clk);
    check("first_mv", 64'(mmu_valid), 64'd1);
    check("first_maddr", mmu_addr, 64'h7005);
    @(posedge clk); #1; mmu_ready = 1'b0;
    @(negedge clk);
    check("first_rv", 64'(rsp_valid), 64'd1);
    check("first_rdata", rsp_rdata, 64'h9A);
    $display("txn reset-mid-access and first-request-after-reset done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
